// File: rtl/serdes_lb_pkg.sv
// Shared constants, state encoding and comma-scan helper for the SERDES loopback RX checker.
// No clocked logic; imported by the checker top and the lane rotator.
package serdes_lb_pkg;

    localparam logic [7:0]  K28_0 = 8'h1C;
    localparam logic [7:0]  K28_5 = 8'hBC;
    localparam logic [7:0]  K28_7 = 8'hFC;

    localparam logic [63:0] EXP_WORD_DEF = 64'h0000_0000_00CA_FEBC;
    localparam logic [7:0]  EXP_K_DEF    = 8'h01;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lb_state_t;

    typedef struct packed {
        logic [63:0] dat;
        logic [7:0]  k;
        logic [7:0]  nit;
        logic [7:0]  disp;
    } rx_word_t;

    // Returns {found, lane}; scanning downwards lets the lowest comma lane win.
    function automatic logic [3:0] comma_scan(input logic [63:0] dat, input logic [7:0] k);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (k[i] && dat[i*8 +: 8] == K28_5) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/serdes_lb_lane_rot.sv
// Byte rotator: output byte b takes input byte (b + lane) mod 8, for both data and K flags.
// Purely combinational, zero latency, no backpressure.
module serdes_lb_lane_rot
    import serdes_lb_pkg::*;
(
    input  logic [63:0] i_dat,
    input  logic [7:0]  i_k,
    input  logic [2:0]  i_lane,
    output logic [63:0] o_dat,
    output logic [7:0]  o_k
);

    always_comb begin
        logic [2:0] v_src;
        v_src = 3'd0;
        o_dat = '0;
        o_k   = '0;
        for (int b = 0; b < 8; b++) begin
            v_src               = 3'(b) + i_lane;
            o_dat[b*8 +: 8]     = i_dat[{v_src, 3'b000} +: 8];
            o_k[b]              = i_k[v_src];
        end
    end

endmodule

// File: rtl/serdes_lb_rx_checker.sv
// Loopback RX checker: locks on the fixed TX pattern, pulses err_o per bad locked word, saturating counters.
// Latency: outputs change 2 RX_CLK_I edges after a word is sampled; no backpressure, one word per clock.
// Optional SERDES_LB_LANE_ALIGN_EN: comma scan in HUNT selects the byte lane; otherwise lane fixed at 0.
module serdes_lb_rx_checker
    import serdes_lb_pkg::*;
#(
    parameter int          LOCK_CNT   = 4,
    parameter int          UNLOCK_CNT = 4,
    parameter logic [63:0] EXP_WORD   = EXP_WORD_DEF,
    parameter logic [7:0]  EXP_K      = EXP_K_DEF,
    parameter int          ERR_CNT_W  = 16,
    parameter int          WORD_CNT_W = 32
) (
    input  logic                  RX_CLK_I,
    input  logic                  rx_rstn_i,
    input  logic                  rx_reset_done_i,
    input  logic [63:0]           rx_data_i,
    input  logic [7:0]            rx_char_is_k_i,
    input  logic [7:0]            rx_not_in_table_i,
    input  logic [7:0]            rx_disp_err_i,
    input  logic                  cnt_clr_i,
    output logic                  locked_o,
    output logic                  err_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
    output logic [WORD_CNT_W-1:0] word_cnt_o,
    output logic [2:0]            lane_o
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

    rx_word_t         r_s1;
    lb_state_t        r_state;
    logic [RUN_W-1:0] r_run;
    logic [MISS_W-1:0] r_miss;

    logic [63:0]       w_rot_dat;
    logic [7:0]        w_rot_k;
    logic              w_comma;
    logic              w_good;
    logic [RUN_W-1:0]  w_run_inc;
    logic [MISS_W-1:0] w_miss_inc;

`ifdef SERDES_LB_LANE_ALIGN_EN
    logic [3:0] w_scan;
    logic [2:0] w_lane;
    logic [2:0] r_lane;

    assign w_scan  = comma_scan(r_s1.dat, r_s1.k);
    assign w_comma = (r_state != HUNT) || w_scan[3];
    assign w_lane  = (r_state == HUNT) ? w_scan[2:0] : r_lane;

    serdes_lb_lane_rot u_lane_rot (
        .i_dat  (r_s1.dat),
        .i_k    (r_s1.k),
        .i_lane (w_lane),
        .o_dat  (w_rot_dat),
        .o_k    (w_rot_k)
    );

    // The lane is latched only when HUNT accepts a word; VERIFY/LOCKED judge against it.
    always_ff @(posedge RX_CLK_I or negedge rx_rstn_i) begin
        if (!rx_rstn_i) begin
            r_lane <= 3'd0;
        end else if (rx_reset_done_i && r_state == HUNT && w_good) begin
            r_lane <= w_scan[2:0];
        end
    end

    assign lane_o = r_lane;
`else
    assign w_comma   = 1'b1;
    assign w_rot_dat = r_s1.dat;
    assign w_rot_k   = r_s1.k;
    assign lane_o    = 3'd0;
`endif

    assign w_good = w_comma && (w_rot_dat == EXP_WORD) && (w_rot_k == EXP_K)
                    && (r_s1.nit == 8'd0) && (r_s1.disp == 8'd0);

    assign w_run_inc  = r_run + RUN_W'(1);
    assign w_miss_inc = r_miss + MISS_W'(1);

    always_ff @(posedge RX_CLK_I or negedge rx_rstn_i) begin
        if (!rx_rstn_i) begin
            r_s1       <= '0;
            r_state    <= HUNT;
            r_run      <= '0;
            r_miss     <= '0;
            locked_o   <= 1'b0;
            err_o      <= 1'b0;
            err_cnt_o  <= '0;
            word_cnt_o <= '0;
        end else begin
            r_s1  <= '{dat: rx_data_i, k: rx_char_is_k_i, nit: rx_not_in_table_i, disp: rx_disp_err_i};
            err_o <= 1'b0;
            if (!rx_reset_done_i) begin
                r_state  <= HUNT;
                r_run    <= '0;
                r_miss   <= '0;
                locked_o <= 1'b0;
            end else begin
                case (r_state)
                    HUNT: begin
                        if (w_good) begin
                            if (LOCK_CNT == 1) begin
                                r_state  <= LOCKED;
                                locked_o <= 1'b1;
                            end else begin
                                r_state <= VERIFY;
                                r_run   <= RUN_W'(1);
                            end
                        end
                    end
                    VERIFY: begin
                        if (!w_good) begin
                            r_state <= HUNT;
                            r_run   <= '0;
                        end else if (w_run_inc == RUN_W'(LOCK_CNT)) begin
                            r_state  <= LOCKED;
                            r_run    <= '0;
                            locked_o <= 1'b1;
                        end else begin
                            r_run <= w_run_inc;
                        end
                    end
                    LOCKED: begin
                        if (w_good) begin
                            r_miss <= '0;
                            if (word_cnt_o != '1) word_cnt_o <= word_cnt_o + WORD_CNT_W'(1);
                        end else begin
                            err_o <= 1'b1;
                            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
                            if (w_miss_inc == MISS_W'(UNLOCK_CNT)) begin
                                r_state  <= HUNT;
                                r_miss   <= '0;
                                locked_o <= 1'b0;
                            end else begin
                                r_miss <= w_miss_inc;
                            end
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        locked_o <= 1'b0;
                    end
                endcase
            end
            // Clear is last so it overrides any same-cycle increment.
            if (cnt_clr_i) begin
                err_cnt_o  <= '0;
                word_cnt_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_serdes_lb_rx_checker.sv
// Self-checking bench for serdes_lb_rx_checker: word-level reference model plus directed literal checks.
// Works with SERDES_LB_LANE_ALIGN_EN defined or undefined.
`timescale 1ns/1ps
module tb_serdes_lb_rx_checker;

    localparam int          LOCK_CNT   = 4;
    localparam int          UNLOCK_CNT = 4;
    localparam int          ERR_W      = 4;
    localparam int          WORD_W     = 8;
    localparam int          ERR_MAX    = (1 << ERR_W) - 1;
    localparam int          WORD_MAX   = (1 << WORD_W) - 1;
    localparam logic [63:0] EXP        = 64'h0000_0000_00CA_FEBC;
    localparam logic [63:0] BAD1       = 64'h0000_0000_00CA_FFBC;
    localparam logic [63:0] ROT3       = 64'h0000_CAFE_BC00_0000;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              reset_done = 1'b0;
    logic [63:0]       rx_data = '0;
    logic [7:0]        rx_k = '0;
    logic [7:0]        rx_nit = '0;
    logic [7:0]        rx_disp = '0;
    logic              clr = 1'b0;
    logic              locked_o;
    logic              err_o;
    logic [ERR_W-1:0]  err_cnt_o;
    logic [WORD_W-1:0] word_cnt_o;
    logic [2:0]        lane_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serdes_lb_rx_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .ERR_CNT_W  (ERR_W),
        .WORD_CNT_W (WORD_W)
    ) dut (
        .RX_CLK_I          (clk),
        .rx_rstn_i         (rstn),
        .rx_reset_done_i   (reset_done),
        .rx_data_i         (rx_data),
        .rx_char_is_k_i    (rx_k),
        .rx_not_in_table_i (rx_nit),
        .rx_disp_err_i     (rx_disp),
        .cnt_clr_i         (clr),
        .locked_o          (locked_o),
        .err_o             (err_o),
        .err_cnt_o         (err_cnt_o),
        .word_cnt_o        (word_cnt_o),
        .lane_o            (lane_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] rot_dat(input logic [63:0] d, input int lane);
        logic [127:0] t;
        t = {d, d} >> (lane * 8);
        return t[63:0];
    endfunction

    function automatic logic [7:0] rot_k(input logic [7:0] k, input int lane);
        logic [15:0] t;
        t = {k, k} >> lane;
        return t[7:0];
    endfunction

    function automatic int find_comma(input logic [63:0] d, input logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            if (k[i] && d[i*8 +: 8] == 8'hBC) return i;
        end
        return -1;
    endfunction

    function automatic bit judge(input logic [63:0] d, input logic [7:0] k, input logic [7:0] n,
                                 input logic [7:0] e, input int lane);
        if (lane < 0) return 1'b0;
        return (rot_dat(d, lane) == EXP) && (rot_k(k, lane) == 8'h01) && (n == 8'd0) && (e == 8'd0);
    endfunction

    int          m_st, m_run, m_miss, m_lane, m_errcnt, m_wordcnt;
    bit          m_err;
    logic [63:0] q_d;
    logic [7:0]  q_k, q_n, q_e;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_st = 0; m_run = 0; m_miss = 0; m_lane = 0;
            m_errcnt = 0; m_wordcnt = 0; m_err = 1'b0;
            q_d = '0; q_k = '0; q_n = '0; q_e = '0;
        end else begin
            int cand;
            m_err = 1'b0;
            if (!reset_done) begin
                m_st = 0; m_run = 0; m_miss = 0;
            end else if (m_st == 0) begin
`ifdef SERDES_LB_LANE_ALIGN_EN
                cand = find_comma(q_d, q_k);
`else
                cand = 0;
`endif
                if (judge(q_d, q_k, q_n, q_e, cand)) begin
                    m_lane = cand;
                    if (LOCK_CNT == 1) m_st = 2;
                    else begin m_st = 1; m_run = 1; end
                end
            end else if (m_st == 1) begin
                if (judge(q_d, q_k, q_n, q_e, m_lane)) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin m_st = 2; m_run = 0; end
                end else begin
                    m_st = 0; m_run = 0;
                end
            end else begin
                if (judge(q_d, q_k, q_n, q_e, m_lane)) begin
                    m_miss = 0;
                    if (m_wordcnt < WORD_MAX) m_wordcnt++;
                end else begin
                    m_err = 1'b1;
                    if (m_errcnt < ERR_MAX) m_errcnt++;
                    m_miss++;
                    if (m_miss == UNLOCK_CNT) begin m_st = 0; m_miss = 0; end
                end
            end
            if (clr) begin m_errcnt = 0; m_wordcnt = 0; end
            q_d = rx_data; q_k = rx_k; q_n = rx_nit; q_e = rx_disp;
        end
    end

    always @(negedge clk) begin
        chk("cyc_locked", 64'(locked_o), 64'(m_st == 2));
        chk("cyc_err", 64'(err_o), 64'(m_err));
        chk("cyc_err_cnt", 64'(err_cnt_o), 64'(m_errcnt));
        chk("cyc_word_cnt", 64'(word_cnt_o), 64'(m_wordcnt));
        chk("cyc_lane", 64'(lane_o), 64'(m_lane));
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic [7:0] n, input logic [7:0] e);
        rx_data = d; rx_k = k; rx_nit = n; rx_disp = e;
        @(posedge clk);
        #2;
    endtask

    task automatic good(input int n);
        repeat (n) send(EXP, 8'h01, 8'h00, 8'h00);
    endtask

    initial begin
        #1 rstn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            reset_done = 1'($urandom);
            clr = 1'($urandom);
            send({$urandom, $urandom}, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        chk("rst_locked", 64'(locked_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt_o), 64'd0);
        chk("rst_lane", 64'(lane_o), 64'd0);
        rstn = 1'b1; reset_done = 1'b1; clr = 1'b0;

        // Lock after the 4th good word is evaluated
        good(4);
        chk("lock_not_yet", 64'(locked_o), 64'd0);
        good(1);
        chk("lock_up", 64'(locked_o), 64'd1);
        chk("lock_wc0", 64'(word_cnt_o), 64'd0);
        good(1);
        chk("lock_wc1", 64'(word_cnt_o), 64'd1);
        good(2);
        chk("lock_wc3", 64'(word_cnt_o), 64'd3);

        // Single error while locked
        send(BAD1, 8'h01, 8'h00, 8'h00);
        good(1);
        chk("single_err_pulse", 64'(err_o), 64'd1);
        chk("single_err_cnt", 64'(err_cnt_o), 64'd1);
        good(1);
        chk("single_err_clear", 64'(err_o), 64'd0);
        chk("single_locked", 64'(locked_o), 64'd1);
        chk("single_wc", 64'(word_cnt_o), 64'd5);

        // Unlock via not-in-table, then relock
        repeat (4) send(EXP, 8'h01, 8'h04, 8'h00);
        chk("unlock_hold", 64'(locked_o), 64'd1);
        good(1);
        chk("unlock_drop", 64'(locked_o), 64'd0);
        chk("unlock_err_cnt", 64'(err_cnt_o), 64'd5);
        good(3);
        chk("relock_not_yet", 64'(locked_o), 64'd0);
        good(1);
        chk("relock_up", 64'(locked_o), 64'd1);

        // Forced HUNT by reset_done low, then a stream shifted to lane 3
        reset_done = 1'b0;
        repeat (2) send(ROT3, 8'h08, 8'h00, 8'h00);
        chk("rd_low_unlock", 64'(locked_o), 64'd0);
        chk("rd_low_keep_cnt", 64'(err_cnt_o), 64'd5);
        reset_done = 1'b1;
        repeat (5) send(ROT3, 8'h08, 8'h00, 8'h00);
`ifdef SERDES_LB_LANE_ALIGN_EN
        chk("lane3_locked", 64'(locked_o), 64'd1);
        chk("lane3_lane", 64'(lane_o), 64'd3);
`else
        chk("lane3_nolock", 64'(locked_o), 64'd0);
        chk("lane3_lane0", 64'(lane_o), 64'd0);
`endif
        chk("lane3_err_cnt", 64'(err_cnt_o), 64'd5);

        // Back to lane 0, then error bursts to saturate the 4-bit counter
        reset_done = 1'b0;
        good(1);
        reset_done = 1'b1;
        good(5);
        chk("lane0_locked", 64'(locked_o), 64'd1);
        chk("lane0_lane", 64'(lane_o), 64'd0);
        for (int b = 0; b < 7; b++) begin
            repeat (3) send(BAD1, 8'h01, 8'h00, 8'h00);
            good(1);
        end
        good(1);
        chk("sat_err_cnt", 64'(err_cnt_o), 64'd15);
        chk("sat_locked", 64'(locked_o), 64'd1);

        // Clear coinciding with a bad word being judged
        send(BAD1, 8'h01, 8'h00, 8'h00);
        clr = 1'b1;
        good(1);
        clr = 1'b0;
        chk("clr_err_pulse", 64'(err_o), 64'd1);
        chk("clr_err_cnt", 64'(err_cnt_o), 64'd0);
        chk("clr_word_cnt", 64'(word_cnt_o), 64'd0);

        // Good-word counter saturation
        good(300);
        chk("wsat_word_cnt", 64'(word_cnt_o), 64'd255);
        chk("wsat_locked", 64'(locked_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
